// File: rtl/cache_lookup_ctrl.sv
// Set-associative tag lookup/allocate controller with true-LRU ages and access statistics.
// Build option: define CACHE_CNT_SAT_EN to make the statistics counters saturate instead of wrap.
module cache_lookup_ctrl #(
    parameter int ADDR_W = 32,
    parameter int SETS   = 16,
    parameter int WAYS   = 4,
    parameter int LINE_B = 64,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [2:0]               req_cmd,
    input  logic [ADDR_W-1:0]        req_addr,
    output logic                     rsp_valid,
    output logic                     rsp_hit,
    output logic [$clog2(WAYS)-1:0]  rsp_way,
    output logic                     rsp_evict,
    output logic [CNT_W-1:0]         cache_read,
    output logic [CNT_W-1:0]         cache_write,
    output logic [CNT_W-1:0]         cache_hit,
    output logic [CNT_W-1:0]         cache_miss
);

    localparam int OFF_W = $clog2(LINE_B);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

    localparam logic [2:0] CMD_READ   = 3'd0;
    localparam logic [2:0] CMD_WRITE  = 3'd1;
    localparam logic [2:0] CMD_IFETCH = 3'd2;
    localparam logic [2:0] CMD_INVAL  = 3'd3;
    localparam logic [2:0] CMD_CLEAR  = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_UPDATE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cmd_q;
    logic [IDX_W-1:0]    idx_q;
    logic [TAG_W-1:0]    tag_q;
    logic                hit_q;
    logic [WAY_W-1:0]    way_q;
    logic                evict_q;

    logic                valid_q   [SETS][WAYS];
    logic [TAG_W-1:0]    tag_arr_q [SETS][WAYS];
    logic [WAY_W-1:0]    age_q     [SETS][WAYS];

    logic [CNT_W-1:0]    cnt_rd_q, cnt_wr_q, cnt_hit_q, cnt_miss_q;

    logic                cmd_access;
    logic                match_hit, inv_found;
    logic [WAY_W-1:0]    match_way, inv_way, lru_way;
    logic                look_hit, look_evict;
    logic [WAY_W-1:0]    look_way;

    // Line offset bits never influence the lookup.
    logic unused_offset;
    assign unused_offset = ^req_addr[OFF_W-1:0];

    assign cmd_access = (cmd_q == CMD_READ) || (cmd_q == CMD_WRITE) || (cmd_q == CMD_IFETCH);

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
`ifdef CACHE_CNT_SAT_EN
        return (&c) ? c : c + CNT_W'(1);
`else
        return c + CNT_W'(1);
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = ST_LOOKUP;
            end
            ST_LOOKUP: state_d = ST_UPDATE;
            ST_UPDATE: begin
                rsp_valid = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rsp_hit   = rsp_valid & hit_q;
    assign rsp_way   = rsp_valid ? way_q : '0;
    assign rsp_evict = rsp_valid & evict_q;

    // Descending scan so the lowest-index match / invalid way wins.
    always_comb begin
        match_hit = 1'b0;
        match_way = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx_q][w] && (tag_arr_q[idx_q][w] == tag_q)) begin
                match_hit = 1'b1;
                match_way = WAY_W'(w);
            end
            if (!valid_q[idx_q][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
            if (age_q[idx_q][w] == WAY_W'(WAYS - 1)) lru_way = WAY_W'(w);
        end
    end

    always_comb begin
        look_hit   = 1'b0;
        look_way   = '0;
        look_evict = 1'b0;
        if (cmd_access) begin
            look_hit = match_hit;
            if (match_hit) begin
                look_way = match_way;
            end else if (inv_found) begin
                look_way = inv_way;
            end else begin
                look_way   = lru_way;
                look_evict = 1'b1;
            end
        end else if (cmd_q == CMD_INVAL) begin
            look_hit = match_hit;
            look_way = match_hit ? match_way : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q   <= '0;
            idx_q   <= '0;
            tag_q   <= '0;
            hit_q   <= 1'b0;
            way_q   <= '0;
            evict_q <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && req_valid) begin
                cmd_q <= req_cmd;
                idx_q <= req_addr[OFF_W +: IDX_W];
                tag_q <= req_addr[ADDR_W-1 -: TAG_W];
            end
            if (state_q == ST_LOOKUP) begin
                hit_q   <= look_hit;
                way_q   <= look_way;
                evict_q <= look_evict;
            end
        end
    end

    // Cache state and statistics commit only in UPDATE, so a reset mid-flight leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_q[s][w]   <= 1'b0;
                    tag_arr_q[s][w] <= '0;
                    age_q[s][w]     <= WAY_W'(w);
                end
            end
            cnt_rd_q   <= '0;
            cnt_wr_q   <= '0;
            cnt_hit_q  <= '0;
            cnt_miss_q <= '0;
        end else if (state_q == ST_UPDATE) begin
            if (cmd_access) begin
                if (!hit_q) begin
                    valid_q[idx_q][way_q]   <= 1'b1;
                    tag_arr_q[idx_q][way_q] <= tag_q;
                end
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == way_q) begin
                        age_q[idx_q][w] <= '0;
                    end else if (age_q[idx_q][w] < age_q[idx_q][way_q]) begin
                        age_q[idx_q][w] <= age_q[idx_q][w] + WAY_W'(1);
                    end
                end
                if (cmd_q == CMD_WRITE) cnt_wr_q <= cnt_inc(cnt_wr_q);
                else                    cnt_rd_q <= cnt_inc(cnt_rd_q);
                if (hit_q) cnt_hit_q  <= cnt_inc(cnt_hit_q);
                else       cnt_miss_q <= cnt_inc(cnt_miss_q);
            end else if (cmd_q == CMD_INVAL) begin
                if (hit_q) valid_q[idx_q][way_q] <= 1'b0;
            end else if (cmd_q == CMD_CLEAR) begin
                for (int s = 0; s < SETS; s++) begin
                    for (int w = 0; w < WAYS; w++) begin
                        valid_q[s][w] <= 1'b0;
                        age_q[s][w]   <= WAY_W'(w);
                    end
                end
                cnt_rd_q   <= '0;
                cnt_wr_q   <= '0;
                cnt_hit_q  <= '0;
                cnt_miss_q <= '0;
            end
        end
    end

    assign cache_read  = cnt_rd_q;
    assign cache_write = cnt_wr_q;
    assign cache_hit   = cnt_hit_q;
    assign cache_miss  = cnt_miss_q;

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Self-checking bench for cache_lookup_ctrl: directed scenarios plus random traffic against a timestamp-LRU model.
module tb_cache_lookup_ctrl;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [2:0]    req_cmd = '0;
    logic [31:0]   req_addr = '0;
    logic          rsp_valid, rsp_hit, rsp_evict;
    logic [1:0]    rsp_way;
    logic [CW-1:0] cache_read, cache_write, cache_hit, cache_miss;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic          rdy;
        logic          v_lookup;
        logic          rdy_lookup;
        logic          v;
        logic          hit;
        logic [1:0]    way;
        logic          ev;
        logic          v_after;
        logic [CW-1:0] rd, wr, hi, mi;
    } obs_t;

    cache_lookup_ctrl #(
        .ADDR_W(32), .SETS(16), .WAYS(4), .LINE_B(64), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_evict(rsp_evict),
        .cache_read(cache_read), .cache_write(cache_write),
        .cache_hit(cache_hit), .cache_miss(cache_miss)
    );

    always #5 clk = ~clk;

    // Reference model: LRU by last-access timestamp, counts kept as plain integers.
    logic        m_valid [16][4];
    logic [21:0] m_tag   [16][4];
    longint      m_ts    [16][4];
    longint      m_time;
    int          raw_rd, raw_wr, raw_hit, raw_miss;

    task automatic model_reset();
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 1'b0;
                m_tag[s][w]   = '0;
                m_ts[s][w]    = -longint'(w);
            end
        m_time = 0;
        raw_rd = 0; raw_wr = 0; raw_hit = 0; raw_miss = 0;
    endtask

    task automatic model_req(input logic [2:0] cmd, input logic [31:0] addr,
                             output logic e_hit, output logic [1:0] e_way, output logic e_ev);
        int s, hw, v;
        logic [21:0] t;
        s = int'(addr[9:6]);
        t = addr[31:10];
        e_hit = 1'b0; e_way = '0; e_ev = 1'b0; hw = -1;
        for (int w = 0; w < 4; w++)
            if (hw < 0 && m_valid[s][w] && m_tag[s][w] == t) hw = w;
        if (cmd <= 3'd2) begin
            if (cmd == 3'd1) raw_wr++; else raw_rd++;
            if (hw >= 0) begin
                e_hit = 1'b1; v = hw; raw_hit++;
            end else begin
                raw_miss++; v = -1;
                for (int w = 0; w < 4; w++) if (v < 0 && !m_valid[s][w]) v = w;
                if (v < 0) begin
                    v = 0;
                    for (int w = 1; w < 4; w++) if (m_ts[s][w] < m_ts[s][v]) v = w;
                    e_ev = 1'b1;
                end
                m_valid[s][v] = 1'b1;
                m_tag[s][v]   = t;
            end
            e_way = 2'(v);
            m_time++;
            m_ts[s][v] = m_time;
        end else if (cmd == 3'd3) begin
            if (hw >= 0) begin
                e_hit = 1'b1; e_way = 2'(hw); m_valid[s][hw] = 1'b0;
            end
        end else if (cmd == 3'd4) begin
            model_reset();
        end
    endtask

    function automatic logic [CW-1:0] cexp(input int raw);
`ifdef CACHE_CNT_SAT_EN
        return (raw > 15) ? 4'd15 : raw[CW-1:0];
`else
        return raw[CW-1:0];
`endif
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives one request and samples the response window; starts and ends on a negedge.
    task automatic do_req(input logic [2:0] cmd, input logic [31:0] addr, output obs_t o);
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        o.rdy = (req_ready === 1'b1);
        req_valid = 1'b1; req_cmd = cmd; req_addr = addr;
        @(negedge clk);
        req_valid = 1'b0;
        o.v_lookup = rsp_valid; o.rdy_lookup = req_ready;
        @(negedge clk);
        o.v = rsp_valid; o.hit = rsp_hit; o.way = rsp_way; o.ev = rsp_evict;
        @(negedge clk);
        o.v_after = rsp_valid;
        o.rd = cache_read; o.wr = cache_write; o.hi = cache_hit; o.mi = cache_miss;
        $display("txn cmd=%0d addr=%08h valid=%b hit=%b way=%0d evict=%b rd=%0d wr=%0d hit_cnt=%0d miss_cnt=%0d",
                 cmd, addr, o.v, o.hit, o.way, o.ev, o.rd, o.wr, o.hi, o.mi);
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({req_ready, rsp_valid, rsp_hit, rsp_way, rsp_evict} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_outputs got ready/valid/hit/way/evict=%b want=100000",
                     {req_ready, rsp_valid, rsp_hit, rsp_way, rsp_evict});
        end
        checks++;
        if ({cache_read, cache_write, cache_hit, cache_miss} !== 16'h0) begin
            errors++;
            $display("FAIL reset_counters got=%h want=0000", {cache_read, cache_write, cache_hit, cache_miss});
        end
    endtask

    task automatic test_hit_after_miss();
        obs_t o;
        apply_reset();
        do_req(3'd0, 32'h1000, o);
        checks++;
        if (!(o.rdy && !o.v_lookup && !o.rdy_lookup && !o.v_after) || o.v !== 1'b1) begin
            errors++;
            $display("FAIL basic_protocol got rdy=%b vlk=%b rdylk=%b v=%b vafter=%b want 1 0 0 1 0",
                     o.rdy, o.v_lookup, o.rdy_lookup, o.v, o.v_after);
        end
        checks++;
        if ({o.hit, o.way, o.ev} !== 4'b0000 || o.rd !== 4'd1 || o.mi !== 4'd1 || o.hi !== 4'd0) begin
            errors++;
            $display("FAIL basic_miss got hit=%b way=%0d ev=%b rd=%0d mi=%0d hi=%0d want 0 0 0 1 1 0",
                     o.hit, o.way, o.ev, o.rd, o.mi, o.hi);
        end
        do_req(3'd0, 32'h1000, o);
        checks++;
        if (o.v !== 1'b1 || {o.hit, o.way, o.ev} !== 4'b1000 || o.hi !== 4'd1 || o.rd !== 4'd2) begin
            errors++;
            $display("FAIL basic_hit got v=%b hit=%b way=%0d ev=%b hi=%0d rd=%0d want 1 1 0 0 1 2",
                     o.v, o.hit, o.way, o.ev, o.hi, o.rd);
        end
    endtask

    task automatic test_fill_evict();
        obs_t o;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            do_req(3'd0, 32'(i * 32'h400), o);
            checks++;
            if (o.v !== 1'b1 || o.hit !== 1'b0 || o.way !== 2'(i) || o.ev !== 1'b0) begin
                errors++;
                $display("FAIL fill_way%0d got v=%b hit=%b way=%0d ev=%b want 1 0 %0d 0", i, o.v, o.hit, o.way, o.ev, i);
            end
        end
        do_req(3'd0, 32'h1000, o);
        checks++;
        if (o.hit !== 1'b0 || o.way !== 2'd0 || o.ev !== 1'b1) begin
            errors++;
            $display("FAIL fill_evict got hit=%b way=%0d ev=%b want 0 0 1", o.hit, o.way, o.ev);
        end
    endtask

    task automatic test_lru_order();
        obs_t o;
        apply_reset();
        for (int i = 0; i < 4; i++) do_req(3'd0, 32'(i * 32'h400), o);
        do_req(3'd0, 32'h0000, o);
        checks++;
        if (o.hit !== 1'b1 || o.way !== 2'd0) begin
            errors++;
            $display("FAIL lru_touch got hit=%b way=%0d want 1 0", o.hit, o.way);
        end
        do_req(3'd0, 32'h1000, o);
        checks++;
        if (o.hit !== 1'b0 || o.way !== 2'd1 || o.ev !== 1'b1) begin
            errors++;
            $display("FAIL lru_victim got hit=%b way=%0d ev=%b want 0 1 1", o.hit, o.way, o.ev);
        end
    endtask

    task automatic test_invalidate();
        obs_t o;
        apply_reset();
        do_req(3'd1, 32'h40, o);
        do_req(3'd3, 32'h40, o);
        checks++;
        if (o.v !== 1'b1 || o.hit !== 1'b1 || o.way !== 2'd0 || o.ev !== 1'b0) begin
            errors++;
            $display("FAIL inval_hit got v=%b hit=%b way=%0d ev=%b want 1 1 0 0", o.v, o.hit, o.way, o.ev);
        end
        do_req(3'd0, 32'h40, o);
        checks++;
        if (o.hit !== 1'b0 || o.wr !== 4'd1 || o.rd !== 4'd1 || o.hi !== 4'd0 || o.mi !== 4'd2) begin
            errors++;
            $display("FAIL inval_counts got hit=%b wr=%0d rd=%0d hi=%0d mi=%0d want 0 1 1 0 2",
                     o.hit, o.wr, o.rd, o.hi, o.mi);
        end
    endtask

    task automatic test_hold_and_clear();
        obs_t o;
        int pulses;
        logic rdy_lk, rdy_up, rdy_back, hit_seen;
        apply_reset();
        do_req(3'd0, 32'h1000, o);
        do_req(3'd0, 32'h1000, o);
        // Keep req_valid high across the whole busy window: only one request may be taken.
        pulses = 0;
        req_valid = 1'b1; req_cmd = 3'd0; req_addr = 32'h2000;
        @(negedge clk);
        rdy_lk = req_ready; pulses += int'(rsp_valid);
        @(negedge clk);
        rdy_up = req_ready; pulses += int'(rsp_valid); hit_seen = rsp_hit;
        @(negedge clk);
        rdy_back = req_ready; pulses += int'(rsp_valid);
        req_valid = 1'b0;
        $display("txn held cmd=0 addr=00002000 pulses=%0d hit=%b rd=%0d", pulses, hit_seen, cache_read);
        checks++;
        if (pulses != 1 || rdy_lk !== 1'b0 || rdy_up !== 1'b0 || rdy_back !== 1'b1 || hit_seen !== 1'b0) begin
            errors++;
            $display("FAIL hold_valid got pulses=%0d ready=%b%b%b hit=%b want 1 001 0",
                     pulses, rdy_lk, rdy_up, rdy_back, hit_seen);
        end
        checks++;
        if (cache_read !== 4'd3 || cache_hit !== 4'd1 || cache_miss !== 4'd2) begin
            errors++;
            $display("FAIL hold_counts got rd=%0d hi=%0d mi=%0d want 3 1 2", cache_read, cache_hit, cache_miss);
        end
        do_req(3'd4, 32'h0, o);
        checks++;
        if (o.v !== 1'b1 || o.hit !== 1'b0 || {o.rd, o.wr, o.hi, o.mi} !== 16'h0) begin
            errors++;
            $display("FAIL clear got v=%b hit=%b counters=%h want 1 0 0000", o.v, o.hit, {o.rd, o.wr, o.hi, o.mi});
        end
        do_req(3'd0, 32'h1000, o);
        checks++;
        if (o.hit !== 1'b0 || o.way !== 2'd0 || o.ev !== 1'b0) begin
            errors++;
            $display("FAIL clear_invalidates got hit=%b way=%0d ev=%b want 0 0 0", o.hit, o.way, o.ev);
        end
    endtask

    task automatic test_reserved();
        obs_t o;
        apply_reset();
        do_req(3'd0, 32'h1000, o);
        for (int c = 5; c < 8; c++) begin
            do_req(3'(c), 32'h1000, o);
            checks++;
            if (o.v !== 1'b1 || {o.hit, o.way, o.ev} !== 4'b0000 || o.rd !== 4'd1 || o.mi !== 4'd1) begin
                errors++;
                $display("FAIL reserved_cmd%0d got v=%b hit=%b way=%0d ev=%b rd=%0d mi=%0d want 1 0 0 0 1 1",
                         c, o.v, o.hit, o.way, o.ev, o.rd, o.mi);
            end
        end
        do_req(3'd0, 32'h1000, o);
        checks++;
        if (o.hit !== 1'b1 || o.way !== 2'd0) begin
            errors++;
            $display("FAIL reserved_nostate got hit=%b way=%0d want 1 0", o.hit, o.way);
        end
    endtask

    task automatic test_reset_inflight();
        obs_t o;
        int pulses;
        apply_reset();
        do_req(3'd0, 32'h1000, o);
        req_valid = 1'b1; req_cmd = 3'd0; req_addr = 32'h3000;
        @(negedge clk);
        req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || {cache_read, cache_miss} !== 8'h0) begin
            errors++;
            $display("FAIL async_reset got ready=%b valid=%b rd=%0d mi=%0d want 1 0 0 0",
                     req_ready, rsp_valid, cache_read, cache_miss);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            pulses += int'(rsp_valid);
        end
        checks++;
        if (pulses != 0 || cache_read !== 4'd0) begin
            errors++;
            $display("FAIL inflight_dropped got pulses=%0d rd=%0d want 0 0", pulses, cache_read);
        end
        do_req(3'd0, 32'h3000, o);
        checks++;
        if (o.hit !== 1'b0 || o.way !== 2'd0) begin
            errors++;
            $display("FAIL inflight_noalloc got hit=%b way=%0d want 0 0", o.hit, o.way);
        end
    endtask

    task automatic test_counter_limit();
        obs_t o;
        logic [CW-1:0] want_rd, want_hi;
        apply_reset();
        for (int i = 0; i < 17; i++) do_req(3'd0, 32'h1000, o);
`ifdef CACHE_CNT_SAT_EN
        want_rd = 4'd15; want_hi = 4'd15;
`else
        want_rd = 4'd1;  want_hi = 4'd0;
`endif
        checks++;
        if (o.rd !== want_rd || o.hi !== want_hi || o.mi !== 4'd1) begin
            errors++;
            $display("FAIL counter_limit got rd=%0d hi=%0d mi=%0d want %0d %0d 1", o.rd, o.hi, o.mi, want_rd, want_hi);
        end
    endtask

    task automatic test_random();
        obs_t o;
        logic e_hit, e_ev;
        logic [1:0] e_way;
        logic [2:0] cmd;
        logic [31:0] addr;
        int r;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      cmd = 3'($urandom_range(0, 2));
            else if (r < 85) cmd = 3'd3;
            else if (r < 88) cmd = 3'd4;
            else             cmd = 3'($urandom_range(5, 7));
            addr = 32'(($urandom_range(0, 5) << 10) | ($urandom_range(0, 2) << 6) | $urandom_range(0, 63));
            do_req(cmd, addr, o);
            model_req(cmd, addr, e_hit, e_way, e_ev);
            checks++;
            if (!(o.rdy && !o.v_lookup && !o.v_after) || o.v !== 1'b1 ||
                o.hit !== e_hit || o.way !== e_way || o.ev !== e_ev) begin
                errors++;
                $display("FAIL rand_rsp[%0d] cmd=%0d addr=%08h got v=%b hit=%b way=%0d ev=%b want 1 %b %0d %b",
                         i, cmd, addr, o.v, o.hit, o.way, o.ev, e_hit, e_way, e_ev);
            end
            checks++;
            if ({o.rd, o.wr, o.hi, o.mi} !== {cexp(raw_rd), cexp(raw_wr), cexp(raw_hit), cexp(raw_miss)}) begin
                errors++;
                $display("FAIL rand_cnt[%0d] got rd/wr/hi/mi=%h want=%h", i, {o.rd, o.wr, o.hi, o.mi},
                         {cexp(raw_rd), cexp(raw_wr), cexp(raw_hit), cexp(raw_miss)});
            end
        end
    endtask

    initial begin
        test_reset();
        test_hit_after_miss();
        test_fill_evict();
        test_lru_order();
        test_invalidate();
        test_hold_and_clear();
        test_reserved();
        test_reset_inflight();
        test_counter_limit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
